// File: rtl/pulse_burst_scheduler.sv
// pulse_burst_scheduler: round-robin arbiter for two requesters
// that sequences a tick-timed pulse train on a shared output.
//
// Ports:
//   CLOCK_50     system clock, rising edge
//   s_reset      synchronous active-high reset
//   tick         one-cycle timing enable (timer rollover)
//   req[1:0]     level request per requester
//   cfg0_pulses  requester 0 pulses per set minus 1
//   cfg0_sets    requester 0 sets minus 1
//   cfg1_pulses  requester 1 pulses per set minus 1
//   cfg1_sets    requester 1 sets minus 1
//   grant[1:0]   one-hot burst owner, 0 when idle
//   busy         burst in progress
//   done         one-cycle pulse on normal completion
//   pulse_out    pulse train (LEDR[0])
module pulse_burst_scheduler #(
   parameter int CFG_W = 3
) (
   input  logic             CLOCK_50,
   input  logic             s_reset,
   input  logic             tick,
   input  logic [1:0]       req,
   input  logic [CFG_W-1:0] cfg0_pulses,
   input  logic [CFG_W-1:0] cfg0_sets,
   input  logic [CFG_W-1:0] cfg1_pulses,
   input  logic [CFG_W-1:0] cfg1_sets,
   output logic [1:0]       grant,
   output logic             busy,
   output logic             done,
   output logic             pulse_out
);

   localparam int CW = CFG_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_HIGH,
      S_LOW,
      S_GAP,
      S_DONE
   } state_t;

   state_t state, state_n;

   logic [CW-1:0] p_lat, p_n;
   logic [CW-1:0] s_lat, s_n;
   logic [CW-1:0] pulse_cnt, pulse_cnt_n;
   logic [CW-1:0] set_cnt, set_cnt_n;
   logic          owner, owner_n;
   logic          rr_ptr, rr_n;
   logic          win;
   logic          active;
   logic          abort;
   logic [1:0]    grant_n;
   logic          busy_n;
   logic          done_n;
   logic          pulse_n;

   // Both asking: pointer decides; otherwise the lone requester.
   assign win = (req == 2'b11) ? rr_ptr : req[1];

   assign active = (state == S_ARM) || (state == S_HIGH) ||
                   (state == S_LOW) || (state == S_GAP);

   // Owner withdrawing its request ends the burst, even on a tick.
   assign abort = active && !req[owner];

   always_comb begin
      state_n     = state;
      p_n         = p_lat;
      s_n         = s_lat;
      pulse_cnt_n = pulse_cnt;
      set_cnt_n   = set_cnt;
      owner_n     = owner;
      rr_n        = rr_ptr;

      if (abort) begin
         state_n = S_IDLE;
         rr_n    = ~owner;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req != 2'b00) begin
                  owner_n     = win;
                  p_n         = win ? {1'b0, cfg1_pulses} + CW'(1)
                                    : {1'b0, cfg0_pulses} + CW'(1);
                  s_n         = win ? {1'b0, cfg1_sets} + CW'(1)
                                    : {1'b0, cfg0_sets} + CW'(1);
                  pulse_cnt_n = '0;
                  set_cnt_n   = '0;
                  state_n     = S_ARM;
               end
            end
            S_ARM: begin
               if (tick) begin
                  state_n     = S_HIGH;
                  pulse_cnt_n = CW'(1);
                  set_cnt_n   = '0;
               end
            end
            S_HIGH: begin
               if (tick) state_n = S_LOW;
            end
            S_LOW: begin
               if (tick) begin
                  if (pulse_cnt < p_lat) begin
                     state_n     = S_HIGH;
                     pulse_cnt_n = pulse_cnt + CW'(1);
                  end else begin
                     state_n   = S_GAP;
                     set_cnt_n = set_cnt + CW'(1);
                  end
               end
            end
            S_GAP: begin
               if (tick) begin
                  if (set_cnt < s_lat) begin
                     state_n     = S_HIGH;
                     pulse_cnt_n = CW'(1);
                  end else begin
                     state_n = S_DONE;
                     rr_n    = ~owner;
                  end
               end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
         endcase
      end

      // Outputs are registered, so derive them from the next state.
      busy_n  = (state_n == S_ARM) || (state_n == S_HIGH) ||
                (state_n == S_LOW) || (state_n == S_GAP);
      grant_n = busy_n ? (owner_n ? 2'b10 : 2'b01) : 2'b00;
      done_n  = (state_n == S_DONE);
      pulse_n = (state_n == S_HIGH);
   end

   always_ff @(posedge CLOCK_50) begin
      if (s_reset) begin
         state     <= S_IDLE;
         p_lat     <= '0;
         s_lat     <= '0;
         pulse_cnt <= '0;
         set_cnt   <= '0;
         owner     <= 1'b0;
         rr_ptr    <= 1'b0;
         grant     <= 2'b00;
         busy      <= 1'b0;
         done      <= 1'b0;
         pulse_out <= 1'b0;
      end else begin
         state     <= state_n;
         p_lat     <= p_n;
         s_lat     <= s_n;
         pulse_cnt <= pulse_cnt_n;
         set_cnt   <= set_cnt_n;
         owner     <= owner_n;
         rr_ptr    <= rr_n;
         grant     <= grant_n;
         busy      <= busy_n;
         done      <= done_n;
         pulse_out <= pulse_n;
      end
   end

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// tb_pulse_burst_scheduler: directed and random stimulus checked
// against a tick-count reference model of the burst schedule.
module tb_pulse_burst_scheduler;

   localparam int CFG_W = 3;

   logic             CLOCK_50 = 1'b0;
   logic             s_reset;
   logic             tick;
   logic [1:0]       req;
   logic [CFG_W-1:0] cfg0_pulses;
   logic [CFG_W-1:0] cfg0_sets;
   logic [CFG_W-1:0] cfg1_pulses;
   logic [CFG_W-1:0] cfg1_sets;
   logic [1:0]       grant;
   logic             busy;
   logic             done;
   logic             pulse_out;

   pulse_burst_scheduler #(.CFG_W(CFG_W)) dut (
      .CLOCK_50    (CLOCK_50),
      .s_reset     (s_reset),
      .tick        (tick),
      .req         (req),
      .cfg0_pulses (cfg0_pulses),
      .cfg0_sets   (cfg0_sets),
      .cfg1_pulses (cfg1_pulses),
      .cfg1_sets   (cfg1_sets),
      .grant       (grant),
      .busy        (busy),
      .done        (done),
      .pulse_out   (pulse_out)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int errors = 0;

   // Model: phase 0 idle, 1 burst running, 2 done cycle.
   // m_k counts ticks consumed since the grant.
   int m_phase = 0;
   int m_k     = 0;
   int m_P     = 1;
   int m_S     = 1;
   bit m_owner = 1'b0;
   bit m_rr    = 1'b0;

   int   tcnt     = 0;
   bit   tick_rnd = 1'b0;
   int   cyc_n    = 0;
   int   ticks_busy;
   int   rises;
   int   dones;
   logic prev_pulse = 1'b0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse high on ticks 1,3,..,2P-1 of each (2P+1)-tick set.
   function automatic bit pat_high(input int k, input int p);
      int t;
      int o;
      if (k < 1) return 1'b0;
      t = k - 1;
      o = t % (2 * p + 1);
      return (o < 2 * p) && (o % 2 == 0);
   endfunction

   task automatic model_edge();
      if (s_reset) begin
         m_phase = 0;
         m_k     = 0;
         m_rr    = 1'b0;
      end else if (m_phase == 0) begin
         if (req != 2'b00) begin
            m_owner = (req == 2'b11) ? m_rr : req[1];
            m_P = m_owner ? int'(cfg1_pulses) + 1
                          : int'(cfg0_pulses) + 1;
            m_S = m_owner ? int'(cfg1_sets) + 1
                          : int'(cfg0_sets) + 1;
            m_k     = 0;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (!req[m_owner]) begin
            m_phase = 0;
            m_rr    = !m_owner;
         end else if (tick) begin
            m_k++;
            if (m_k == 1 + m_S * (2 * m_P + 1)) begin
               m_phase = 2;
               m_rr    = !m_owner;
            end
         end
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic cyc();
      logic [1:0] eg;
      if (busy === 1'b1 && tick === 1'b1 && !s_reset)
         ticks_busy++;
      @(posedge CLOCK_50);
      model_edge();
      #1;
      cyc_n++;
      eg = (m_phase == 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("grant", 32'(grant), 32'(eg));
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("pulse_out", 32'(pulse_out),
          32'((m_phase == 1) && pat_high(m_k, m_P)));
      if (pulse_out === 1'b1 && prev_pulse !== 1'b1) rises++;
      prev_pulse = pulse_out;
      if (done === 1'b1) dones++;
      tcnt++;
      tick = tick_rnd ? ($urandom_range(0, 2) == 0)
                      : (tcnt % 4 == 0);
   endtask

   task automatic run_until_done(input int bound, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < bound && !seen; n++) begin
         cyc();
         if (done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic clr_meas();
      ticks_busy = 0;
      rises      = 0;
      dones      = 0;
   endtask

   initial begin
      bit         seen;
      logic [1:0] gq[$];
      int         last_done;
      logic [1:0] prev_g;

      s_reset     = 1'b1;
      tick        = 1'b0;
      req         = 2'b00;
      cfg0_pulses = '0;
      cfg0_sets   = '0;
      cfg1_pulses = '0;
      cfg1_sets   = '0;
      clr_meas();

      // Reset
      cyc();
      cyc();
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_pulse", 32'(pulse_out), 32'(0));
      s_reset = 1'b0;
      cyc();

      // Single burst P=3 S=2
      cfg0_pulses = 3'd2;
      cfg0_sets   = 3'd1;
      req         = 2'b01;
      clr_meas();
      cyc();
      chk("t1_grant_1clk", 32'(grant), 32'(2'b01));
      run_until_done(300, seen);
      chk("t1_done_seen", 32'(seen), 32'(1));
      req = 2'b00;
      chk("t1_ticks", 32'(ticks_busy), 32'(15));
      chk("t1_pulses", 32'(rises), 32'(6));
      cyc();
      chk("t1_done_1clk", 32'(done), 32'(0));
      chk("t1_busy_low", 32'(busy), 32'(0));
      chk("t1_done_cnt", 32'(dones), 32'(1));

      // Minimum burst
      cfg0_pulses = 3'd0;
      cfg0_sets   = 3'd0;
      req         = 2'b01;
      clr_meas();
      cyc();
      run_until_done(100, seen);
      chk("min_done_seen", 32'(seen), 32'(1));
      req = 2'b00;
      chk("min_ticks", 32'(ticks_busy), 32'(4));
      chk("min_pulses", 32'(rises), 32'(1));
      cyc();

      // Contention from reset
      s_reset = 1'b1;
      cyc();
      s_reset     = 1'b0;
      cfg0_pulses = 3'd1;
      cfg0_sets   = 3'd0;
      cfg1_pulses = 3'd0;
      cfg1_sets   = 3'd1;
      req         = 2'b11;
      prev_g      = 2'b00;
      last_done   = 0;
      for (int n = 0; n < 600 && gq.size() < 3; n++) begin
         cyc();
         if (done === 1'b1) last_done = cyc_n;
         if (grant != 2'b00 && prev_g == 2'b00) begin
            if (gq.size() > 0)
               chk("ct_regrant_gap", 32'(cyc_n - last_done), 32'(2));
            gq.push_back(grant);
         end
         prev_g = grant;
      end
      chk("ct_grant_cnt", 32'(gq.size()), 32'(3));
      if (gq.size() == 3) begin
         chk("ct_g0", 32'(gq[0]), 32'(2'b01));
         chk("ct_g1", 32'(gq[1]), 32'(2'b10));
         chk("ct_g2", 32'(gq[2]), 32'(2'b01));
      end
      req = 2'b00;
      cyc();
      cyc();

      // Configuration stability
      cfg0_pulses = 3'd1;
      cfg0_sets   = 3'd0;
      req         = 2'b01;
      clr_meas();
      cyc();
      for (int n = 0; n < 6; n++) cyc();
      cfg0_pulses = 3'd7;
      run_until_done(200, seen);
      chk("cs_done1", 32'(seen), 32'(1));
      chk("cs_pulses_old", 32'(rises), 32'(2));
      req = 2'b00;
      cyc();
      clr_meas();
      req = 2'b01;
      run_until_done(400, seen);
      chk("cs_done2", 32'(seen), 32'(1));
      chk("cs_pulses_new", 32'(rises), 32'(8));
      req = 2'b00;
      cyc();

      // Abort during second pulse
      s_reset = 1'b1;
      cyc();
      s_reset     = 1'b0;
      cfg0_pulses = 3'd2;
      cfg0_sets   = 3'd0;
      cfg1_pulses = 3'd0;
      cfg1_sets   = 3'd0;
      req         = 2'b11;
      clr_meas();
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         cyc();
         if (rises == 2 && pulse_out === 1'b1) seen = 1'b1;
      end
      chk("ab_second_pulse", 32'(seen), 32'(1));
      req = 2'b10;
      cyc();
      chk("ab_pulse", 32'(pulse_out), 32'(0));
      chk("ab_grant", 32'(grant), 32'(0));
      chk("ab_busy", 32'(busy), 32'(0));
      chk("ab_no_done", 32'(dones), 32'(0));
      cyc();
      chk("ab_regrant", 32'(grant), 32'(2'b10));
      run_until_done(200, seen);
      chk("ab_done1", 32'(seen), 32'(1));
      req = 2'b00;
      cyc();

      // Reset mid-burst, coincident with tick
      cfg0_pulses = 3'd3;
      cfg0_sets   = 3'd2;
      cfg1_pulses = 3'd1;
      cfg1_sets   = 3'd1;
      req         = 2'b11;
      seen        = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         cyc();
         if (pulse_out === 1'b1) seen = 1'b1;
      end
      chk("rm_in_burst", 32'(seen), 32'(1));
      s_reset = 1'b1;
      tick    = 1'b1;
      dones   = 0;
      cyc();
      chk("rm_grant", 32'(grant), 32'(0));
      chk("rm_busy", 32'(busy), 32'(0));
      chk("rm_pulse", 32'(pulse_out), 32'(0));
      chk("rm_done", 32'(done), 32'(0));
      s_reset = 1'b0;
      cyc();
      chk("rm_regrant", 32'(grant), 32'(2'b01));
      req = 2'b00;
      cyc();
      cyc();

      // Random traffic
      tick_rnd = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 99) == 0) req[0] = ~req[0];
         if ($urandom_range(0, 99) == 0) req[1] = ~req[1];
         if ($urandom_range(0, 29) == 0) begin
            cfg0_pulses = CFG_W'($urandom);
            cfg0_sets   = CFG_W'($urandom);
            cfg1_pulses = CFG_W'($urandom);
            cfg1_sets   = CFG_W'($urandom);
         end
         s_reset = ($urandom_range(0, 599) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
